switch_allocator: RTL and testbench
===================================

Name: switch_allocator

Overview:
- Wormhole switch allocator for one router. Sits between the per-input head-flit decoders and the crossbar.
- Each input presents its decoded output-port request. For every output port, the allocator round-robin arbitrates among requesting inputs.
- The winner keeps the output until that input's tail flit has transferred. The allocator drives the crossbar select lines and the input/output valid-ready handshakes.

Parameters:
- PORTS, 4, number of router ports (inputs = outputs).
- REQUEST_WIDTH, 2, width of one output-port index; must be >= $clog2(PORTS).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  PORTS  bit i: front flit of input i is a head flit with its decoded request valid.
- req_port  input  PORTS*REQUEST_WIDTH  slice i: requested output index for input i.
- flit_valid  input  PORTS  bit i: input i has a flit available.
- flit_tail  input  PORTS  bit i: the flit at input i is a tail flit (head+tail = single-flit packet).
- out_ready  input  PORTS  bit o: downstream of output o accepts a flit this cycle.
- out_valid  output  PORTS  bit o: output o presents a valid flit.
- out_sel  output  PORTS*REQUEST_WIDTH  slice o: input index routed to output o by the crossbar.
- out_locked  output  PORTS  bit o: output o is owned by an input.
- in_ready  output  PORTS  bit i: the flit at input i is consumed this cycle.

Behaviour:
- Reset (rst=0, async): all outputs IDLE, owners 0, round-robin pointers 0, out_valid=0, out_sel=0, out_locked=0, in_ready=0.
- Per-output state machine, one per output o:
  - IDLE -> LOCKED when at least one eligible request exists.
  - LOCKED -> IDLE on the tail transfer.
- Eligible request for output o: req_valid[i]=1, req_port[i]==o, and input i is not currently the owner of any output.
  - Requests with req_port >= PORTS are ignored.
  - Requests from an input that is already an owner are masked.
- Arbitration in IDLE:
  - Winner = first eligible i searching i = ptr_o, ptr_o+1, ... mod PORTS.
  - Registered: owner_o <= winner, state <= LOCKED, ptr_o <= (winner+1) mod PORTS.
  - Different outputs arbitrate independently in the same cycle. An input requests only one output, so there are no cross-output conflicts.
- LOCKED (combinational outputs from registered state):
  - out_locked[o]=1, out_sel[o]=owner_o.
  - out_valid[o]=flit_valid[owner_o].
  - in_ready[owner_o]=out_ready[o].
- Transfer occurs when flit_valid[owner_o] && out_ready[o].
  - If a transfer occurs with flit_tail[owner_o]=1, the next state is IDLE and the pointer is unchanged.
- IDLE outputs: out_valid=0, out_locked=0, out_sel holds the last owner (don't-care to downstream). Inputs with no owned output have in_ready=0.
- Latency:
  - Request seen at edge t gives LOCKED after edge t; the head flit can transfer in cycle t+1.
  - Minimum one cycle from tail transfer to the next grant on the same output (one idle bubble). This bubble is required.
- Simultaneous tail transfer and a new request for the same output: the request is not granted that cycle; it is arbitrated from IDLE next cycle.
- Stalls (out_ready=0 or flit_valid=0) while LOCKED: hold owner indefinitely, no timeout.
- Reset asserted mid-packet: immediately IDLE and all handshakes deasserted. The packet in flight is abandoned; upstream flushing is outside this block.

Decomposition:
- Shared package (noc_alloc_pkg):
  - state encoding IDLE=1'b0, LOCKED=1'b1;
  - default PORTS / REQUEST_WIDTH constants;
  - a function extracting slice k of a packed REQUEST_WIDTH vector.
- Sub-module output_arbiter: one output's FSM, owner register, and round-robin pointer and search. Instantiated PORTS times via generate.
- Top level:
  - builds per-output eligible vectors from req_valid/req_port and the owner mask;
  - ORs per-output in_ready contributions into in_ready.

Test Plan:
- Reset then single request: req_valid=0001, req_port[0]=2, flit_valid[0]=1, out_ready=1111, 3-flit packet (tail on flit 3) -> out_locked[2]=1 one cycle later, out_sel[2]=0, three transfers on out_valid[2]/in_ready[0], then IDLE.
- Contention: inputs 0,1,3 all request output 1 and hold requests, 1-flit packets -> grants in order 0,1,3,0, with one idle cycle between grants.
- Backpressure: owner input 2 on output 0, out_ready[0] toggles 1,0,0,1 -> in_ready[2] mirrors out_ready[0], and the tail completes only on a cycle with ready=1.
- Parallel: input 0 -> output 3 and input 1 -> output 2 in the same cycle -> both locked next cycle, with independent transfers.
- Masking: input 0 owns output 1 and asserts req_valid with req_port=2 mid-packet -> output 2 stays IDLE until input 0's tail transfers.
- Async reset mid-packet: pull rst low between clock edges while LOCKED -> out_valid, in_ready, out_locked drop to 0 without waiting for an edge; after release, pointers restart at 0 (input 0 wins a 0/1 tie).

Source files
------------

// File: rtl/noc_alloc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | noc_alloc_pkg : shared constants and helpers for the switch allocator      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package noc_alloc_pkg;

  localparam int unsigned PORTS_DEFAULT         = 4;
  localparam int unsigned REQUEST_WIDTH_DEFAULT = 2;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  // Callers zero-extend their packed vector to this width before slicing.
  localparam int unsigned MAX_SLICE_BITS = 1024;

  function automatic logic [31:0] getSlice(
    input logic [MAX_SLICE_BITS-1:0] vec,
    input int unsigned               k,
    input int unsigned               width
  );
    logic [31:0] mask;
    mask     = (32'd1 << width) - 32'd1;
    getSlice = 32'(vec >> (k * width)) & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/output_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | output_arbiter : per-output round-robin grant with wormhole ownership      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module output_arbiter
  import noc_alloc_pkg::*;
#(
  parameter int unsigned PORTS         = PORTS_DEFAULT,
  parameter int unsigned REQUEST_WIDTH = REQUEST_WIDTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PORTS-1:0]         i_eligible,
  input  logic [PORTS-1:0]         i_flitValid,
  input  logic [PORTS-1:0]         i_flitTail,
  input  logic                     i_outReady,
  output logic                     o_locked,
  output logic [REQUEST_WIDTH-1:0] o_owner,
  output logic                     o_outValid,
  output logic [PORTS-1:0]         o_inReady
);

  logic [0:0]               r_state;
  logic [REQUEST_WIDTH-1:0] r_owner;
  logic [REQUEST_WIDTH-1:0] r_ptr;

  logic                     w_found;
  logic [REQUEST_WIDTH-1:0] w_winner;
  logic [REQUEST_WIDTH-1:0] w_nextPtr;
  int unsigned              w_bestDist;
  int unsigned              w_dist;
  logic                     w_ownerValid;
  logic                     w_ownerTail;
  logic                     w_tailDone;

  // Winner is the eligible input at the smallest rotated distance from r_ptr.
  always_comb begin
    w_found    = 1'b0;
    w_winner   = '0;
    w_bestDist = PORTS;
    w_dist     = 0;
    for (int i = 0; i < PORTS; i++) begin
      w_dist = (i + PORTS - int'(r_ptr)) % PORTS;
      if (i_eligible[i] && (w_dist < w_bestDist)) begin
        w_bestDist = w_dist;
        w_winner   = REQUEST_WIDTH'(i);
        w_found    = 1'b1;
      end
    end
    w_nextPtr = REQUEST_WIDTH'((int'(w_winner) + 1) % PORTS);
  end

  always_comb begin
    w_ownerValid = 1'b0;
    w_ownerTail  = 1'b0;
    o_inReady    = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (r_owner == REQUEST_WIDTH'(i)) begin
        w_ownerValid = i_flitValid[i];
        w_ownerTail  = i_flitTail[i];
        o_inReady[i] = (r_state == LOCKED) && i_outReady;
      end
    end
  end

  assign o_locked   = (r_state == LOCKED);
  assign o_owner    = r_owner;
  assign o_outValid = o_locked && w_ownerValid;
  assign w_tailDone = o_locked && w_ownerValid && i_outReady && w_ownerTail;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state <= LOCKED;
            r_owner <= w_winner;
            r_ptr   <= w_nextPtr;
          end
        end
        LOCKED: begin
          if (w_tailDone) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/switch_allocator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | switch_allocator : wormhole switch allocator driving crossbar selects      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module switch_allocator
  import noc_alloc_pkg::*;
#(
  parameter int unsigned PORTS         = PORTS_DEFAULT,
  parameter int unsigned REQUEST_WIDTH = REQUEST_WIDTH_DEFAULT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PORTS-1:0]                 req_valid,
  input  logic [PORTS*REQUEST_WIDTH-1:0]   req_port,
  input  logic [PORTS-1:0]                 flit_valid,
  input  logic [PORTS-1:0]                 flit_tail,
  input  logic [PORTS-1:0]                 out_ready,
  output logic [PORTS-1:0]                 out_valid,
  output logic [PORTS*REQUEST_WIDTH-1:0]   out_sel,
  output logic [PORTS-1:0]                 out_locked,
  output logic [PORTS-1:0]                 in_ready
);

  logic [MAX_SLICE_BITS-1:0] w_reqPortPad;
  logic [31:0]               w_reqIdx [PORTS];
  logic [PORTS-1:0]          w_isOwner;
  logic [PORTS-1:0]          w_locked;
  logic [REQUEST_WIDTH-1:0]  w_owner [PORTS];
  logic [PORTS-1:0]          w_inReadyPart [PORTS];

  assign w_reqPortPad = MAX_SLICE_BITS'(req_port);

  for (genvar i = 0; i < PORTS; i++) begin : g_reqDecode
    assign w_reqIdx[i] = getSlice(w_reqPortPad, i, REQUEST_WIDTH);
  end

  // An input holding any output may not compete for another one.
  always_comb begin
    w_isOwner = '0;
    for (int o = 0; o < PORTS; o++) begin
      for (int i = 0; i < PORTS; i++) begin
        if (w_locked[o] && (w_owner[o] == REQUEST_WIDTH'(i))) begin
          w_isOwner[i] = 1'b1;
        end
      end
    end
  end

  for (genvar o = 0; o < PORTS; o++) begin : g_output
    logic [PORTS-1:0] w_eligible;

    // Out-of-range request indices never match any o, so they are dropped here.
    always_comb begin
      w_eligible = '0;
      for (int i = 0; i < PORTS; i++) begin
        w_eligible[i] = req_valid[i] && !w_isOwner[i] && (w_reqIdx[i] == 32'(o));
      end
    end

    output_arbiter #(
      .PORTS         (PORTS),
      .REQUEST_WIDTH (REQUEST_WIDTH)
    ) u_outputArbiter (
      .clk         (clk),
      .rst         (rst),
      .i_eligible  (w_eligible),
      .i_flitValid (flit_valid),
      .i_flitTail  (flit_tail),
      .i_outReady  (out_ready[o]),
      .o_locked    (w_locked[o]),
      .o_owner     (w_owner[o]),
      .o_outValid  (out_valid[o]),
      .o_inReady   (w_inReadyPart[o])
    );

    assign out_sel[o*REQUEST_WIDTH +: REQUEST_WIDTH] = w_owner[o];
  end

  assign out_locked = w_locked;

  always_comb begin
    in_ready = '0;
    for (int o = 0; o < PORTS; o++) begin
      in_ready = in_ready | w_inReadyPart[o];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_switch_allocator.sv
`default_nettype none
// Self-checking bench for switch_allocator: directed scenarios, a reference
// model of the allocation rules, and a per-cycle comparison against it.
module tb_switch_allocator;

  localparam int P  = 4;
  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [P-1:0]  req_valid  = '0;
  logic [P*RW-1:0] req_port = '0;
  logic [P-1:0]  flit_valid = '0;
  logic [P-1:0]  flit_tail  = '0;
  logic [P-1:0]  out_ready  = '0;
  logic [P-1:0]  out_valid;
  logic [P*RW-1:0] out_sel;
  logic [P-1:0]  out_locked;
  logic [P-1:0]  in_ready;

  int nAssert = 0;
  int nFail   = 0;

  switch_allocator #(.PORTS(P), .REQUEST_WIDTH(RW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_port   (req_port),
    .flit_valid (flit_valid),
    .flit_tail  (flit_tail),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_sel    (out_sel),
    .out_locked (out_locked),
    .in_ready   (in_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: per output a lock bit, owner index and round-robin pointer.
  logic [P-1:0]    mLocked;
  logic [P*RW-1:0] mOwner;
  logic [P*RW-1:0] mPtr;

  function automatic logic [P+2*P*RW-1:0] modelNext();
    logic [P-1:0]    nl;
    logic [P*RW-1:0] nw;
    logic [P*RW-1:0] nq;
    logic [P-1:0]    busy;
    logic [1:0]      c;
    logic [1:0]      own;
    bit              granted;
    nl   = mLocked;
    nw   = mOwner;
    nq   = mPtr;
    busy = '0;
    for (int o = 0; o < P; o++)
      if (mLocked[o]) busy[mOwner[o*RW +: RW]] = 1'b1;
    for (int o = 0; o < P; o++) begin
      own = mOwner[o*RW +: RW];
      if (mLocked[o]) begin
        if (flit_valid[own] && out_ready[o] && flit_tail[own]) nl[o] = 1'b0;
      end else begin
        granted = 1'b0;
        for (int k = 0; k < P; k++) begin
          c = mPtr[o*RW +: RW] + 2'(k);
          if (!granted && req_valid[c] && !busy[c] && (req_port[int'(c)*RW +: RW] == 2'(o))) begin
            granted         = 1'b1;
            nl[o]           = 1'b1;
            nw[o*RW +: RW]  = c;
            nq[o*RW +: RW]  = c + 2'd1;
          end
        end
      end
    end
    return {nl, nw, nq};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) {mLocked, mOwner, mPtr} <= '0;
    else      {mLocked, mOwner, mPtr} <= modelNext();
  end

  always @(negedge clk) begin
    logic [P-1:0] eV;
    logic [P-1:0] eR;
    logic [1:0]   own;
    eV = '0;
    eR = '0;
    for (int o = 0; o < P; o++) begin
      own = mOwner[o*RW +: RW];
      if (mLocked[o]) begin
        eV[o] = flit_valid[own];
        if (out_ready[o]) eR[own] = 1'b1;
      end
    end
    check("cmp_out_locked", 32'(out_locked), 32'(mLocked));
    check("cmp_out_sel",    32'(out_sel),    32'(mOwner));
    check("cmp_out_valid",  32'(out_valid),  32'(eV));
    check("cmp_in_ready",   32'(in_ready),   32'(eR));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input int i, input logic [1:0] p);
    req_port[i*RW +: RW] = p;
  endtask

  int t2Locked [7] = '{1, 0, 1, 0, 1, 0, 1};
  int t2Sel    [7] = '{0, 0, 1, 0, 3, 0, 0};

  initial begin
    #3;
    check("reset_locked", 32'(out_locked), 32'h0);
    check("reset_valid",  32'(out_valid),  32'h0);
    check("reset_ready",  32'(in_ready),   32'h0);
    check("reset_sel",    32'(out_sel),    32'h0);
    #9 rst = 1'b1;

    // Single 3-flit packet, input 0 -> output 2
    step();
    setReq(0, 2'd2);
    req_valid = 4'b0001; flit_valid = 4'b0001; flit_tail = 4'b0000; out_ready = 4'b1111;
    #2 check("t1_not_yet", 32'(out_locked), 32'h0);
    step();
    req_valid = 4'b0000;
    #2;
    check("t1_locked",   32'(out_locked),   32'b0100);
    check("t1_sel",      32'(out_sel[5:4]), 32'd0);
    check("t1_valid",    32'(out_valid),    32'b0100);
    check("t1_in_ready", 32'(in_ready),     32'b0001);
    step();
    step();
    flit_tail = 4'b0001;
    #2 check("t1_tail_valid", 32'(out_valid), 32'b0100);
    step();
    flit_valid = 4'b0000; flit_tail = 4'b0000;
    #2 check("t1_idle", 32'(out_locked), 32'h0);

    // Contention on output 1 from inputs 0, 1, 3
    setReq(0, 2'd1); setReq(1, 2'd1); setReq(3, 2'd1);
    req_valid = 4'b1011; flit_valid = 4'b1011; flit_tail = 4'b1011;
    for (int k = 0; k < 7; k++) begin
      step();
      #2;
      check("t2_locked", 32'(out_locked[1]), 32'(t2Locked[k]));
      if (t2Locked[k] == 1) check("t2_sel", 32'(out_sel[3:2]), 32'(t2Sel[k]));
    end
    req_valid = 4'b0000;
    step();
    flit_valid = 4'b0000; flit_tail = 4'b0000;
    #2 check("t2_idle", 32'(out_locked), 32'h0);

    // Backpressure: input 2 owns output 0
    setReq(2, 2'd0);
    req_valid = 4'b0100; flit_valid = 4'b0100; flit_tail = 4'b0000; out_ready = 4'b0001;
    step();
    req_valid = 4'b0000;
    #2;
    check("t3_ready_hi", 32'(in_ready),   32'b0100);
    check("t3_locked",   32'(out_locked), 32'b0001);
    step();
    flit_tail = 4'b0100; out_ready = 4'b0000;
    #2;
    check("t3_ready_lo", 32'(in_ready),  32'h0);
    check("t3_valid",    32'(out_valid), 32'b0001);
    step();
    #2 check("t3_hold", 32'(out_locked), 32'b0001);
    out_ready = 4'b0001;
    #1 check("t3_ready_back", 32'(in_ready), 32'b0100);
    step();
    flit_valid = 4'b0000; flit_tail = 4'b0000; out_ready = 4'b1111;
    #2 check("t3_idle", 32'(out_locked), 32'h0);

    // Parallel grants: input 0 -> output 3, input 1 -> output 2
    setReq(0, 2'd3); setReq(1, 2'd2);
    req_valid = 4'b0011; flit_valid = 4'b0011; flit_tail = 4'b0000;
    step();
    req_valid = 4'b0000; flit_tail = 4'b0010;
    #2;
    check("t4_locked",   32'(out_locked),   32'b1100);
    check("t4_sel3",     32'(out_sel[7:6]), 32'd0);
    check("t4_sel2",     32'(out_sel[5:4]), 32'd1);
    check("t4_in_ready", 32'(in_ready),     32'b0011);
    step();
    flit_tail = 4'b0001;
    #2;
    check("t4_one_left", 32'(out_locked), 32'b1000);
    check("t4_ready0",   32'(in_ready),   32'b0001);
    step();
    flit_valid = 4'b0000; flit_tail = 4'b0000;
    #2 check("t4_idle", 32'(out_locked), 32'h0);

    // Owner masking: input 0 holds output 1 while requesting output 2
    setReq(0, 2'd1);
    req_valid = 4'b0001; flit_valid = 4'b0001; flit_tail = 4'b0000;
    step();
    setReq(0, 2'd2);
    #2 check("t5_lock1", 32'(out_locked), 32'b0010);
    step();
    #2 check("t5_masked", 32'(out_locked), 32'b0010);
    flit_tail = 4'b0001;
    step();
    #2 check("t5_bubble", 32'(out_locked), 32'h0);
    step();
    #2;
    check("t5_lock2", 32'(out_locked),   32'b0100);
    check("t5_sel2",  32'(out_sel[5:4]), 32'd0);
    req_valid = 4'b0000;
    step();
    flit_valid = 4'b0000; flit_tail = 4'b0000;
    #2 check("t5_idle", 32'(out_locked), 32'h0);

    // Asynchronous reset mid-packet, then pointer restart
    setReq(3, 2'd1);
    req_valid = 4'b1000; flit_valid = 4'b1000; flit_tail = 4'b0000;
    step();
    req_valid = 4'b0000;
    #2;
    check("t6_locked",   32'(out_locked), 32'b0010);
    check("t6_valid",    32'(out_valid),  32'b0010);
    check("t6_in_ready", 32'(in_ready),   32'b1000);
    rst = 1'b0;
    #1;
    check("t6_rst_locked", 32'(out_locked), 32'h0);
    check("t6_rst_valid",  32'(out_valid),  32'h0);
    check("t6_rst_ready",  32'(in_ready),   32'h0);
    step();
    rst = 1'b1;
    flit_valid = 4'b0000;
    setReq(0, 2'd2); setReq(1, 2'd2);
    req_valid = 4'b0011; flit_valid = 4'b0011; flit_tail = 4'b0011;
    step();
    #2;
    check("t6_tie_locked", 32'(out_locked),   32'b0100);
    check("t6_tie_sel",    32'(out_sel[5:4]), 32'd0);
    req_valid = 4'b0000;
    step();
    flit_valid = 4'b0000; flit_tail = 4'b0000;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
